rand_num_arbiter: RTL and testbench

Shares one LFSR-based random-number source between NREQ requesters.
- Grants the source one-hot, round-robin, one draw per cycle.
- Returns the current pseudo-random value with a valid strobe, then advances the LFSR only on a grant, so no value is ever skipped or duplicated.
- Also handles seed loading and zero-state lock-up recovery.
- Sits between the random-counter datapath and its consumers.

---
 rtl/rand_pkg.sv | 44 ++++
 rtl/lfsr_core.sv | 31 +++
 rtl/rand_num_arbiter.sv | 79 +++++++
 tb/tb_rand_num_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared constants and combinational helpers for the random-number arbiter.
package rand_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam logic [WIDTH_DEFAULT-1:0] SEED_DEFAULT = 4'b1001;
  // Feedback taps for x^4+x^3+1: bits 3 and 2.
  localparam logic [WIDTH_DEFAULT-1:0] LFSR_TAP = 4'b1100;
  localparam int unsigned RR_MAX = 32;

  function automatic logic [WIDTH_DEFAULT-1:0] lfsr_next(
    input logic [WIDTH_DEFAULT-1:0] state,
    input logic [WIDTH_DEFAULT-1:0] seed
  );
    if (state == '0) begin
      return seed;
    end
    return {state[WIDTH_DEFAULT-2:0], ^(state & LFSR_TAP)};
  endfunction

  // First set request scanning last_ptr+1, last_ptr+2, ... modulo nreq.
  function automatic int unsigned rr_pick(
    input logic [RR_MAX-1:0] req,
    input int unsigned nreq,
    input int unsigned last_ptr
  );
    int unsigned idx;
    int unsigned win;
    logic found;
    win = 0;
    found = 1'b0;
    for (int unsigned i = 1; i <= RR_MAX; i++) begin
      if (i <= nreq) begin
        idx = last_ptr + i;
        if (idx >= nreq) idx = idx - nreq;
        if (!found && req[idx[4:0]]) begin
          win = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state holder: seed load takes precedence over stepping.
module lfsr_core
  import rand_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] SEED = SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEED;
    end else if (load) begin
      // A zero seed would lock the register, so substitute the default.
      r_state <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      r_state <= lfsr_next(r_state, SEED);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/rand_num_arbiter.sv
// Round-robin arbiter handing out one LFSR draw per cycle to NREQ requesters.
module rand_num_arbiter
  import rand_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned NREQ  = 2,
  parameter logic [WIDTH-1:0] SEED = SEED_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] num,
  output logic             num_valid,
  output logic [CNT_W-1:0] draw_cnt
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [NREQ-1:0]   r_gnt;
  logic [WIDTH-1:0]  r_num;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  r_last_ptr;

  logic [WIDTH-1:0]  w_state;
  logic              w_grant;
  logic [RR_MAX-1:0] w_req_ext;
  int unsigned       w_winner_int;
  logic [PTR_W-1:0]  w_winner;
  logic [NREQ-1:0]   w_onehot;

  assign w_grant      = !seed_load && (|req);
  assign w_req_ext    = RR_MAX'(req);
  assign w_winner_int = rr_pick(w_req_ext, NREQ, 32'(r_last_ptr));
  assign w_winner     = PTR_W'(w_winner_int);
  assign w_onehot     = NREQ'(1) << w_winner;

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (w_grant),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (w_state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt      <= '0;
      r_num      <= '0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
      r_last_ptr <= PTR_W'(NREQ - 1);
    end else if (w_grant) begin
      // num captures the pre-step value so no draw is skipped.
      r_gnt      <= w_onehot;
      r_num      <= w_state;
      r_valid    <= 1'b1;
      r_cnt      <= r_cnt + CNT_W'(1);
      r_last_ptr <= w_winner;
    end else begin
      r_gnt   <= '0;
      r_valid <= 1'b0;
    end
  end

  assign gnt       = r_gnt;
  assign num       = r_num;
  assign num_valid = r_valid;
  assign draw_cnt  = r_cnt;

endmodule

// File: tb/tb_rand_num_arbiter.sv
// Directed bench for rand_num_arbiter with hand-computed expected values.
module tb_rand_num_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic        seed_load;
  logic [3:0]  seed_in;
  logic [1:0]  gnt;
  logic [3:0]  num;
  logic        num_valid;
  logic [15:0] draw_cnt;

  int n_checks;
  int n_errors;

  rand_num_arbiter #(
    .WIDTH (4),
    .NREQ  (2),
    .SEED  (4'b1001),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .gnt       (gnt),
    .num       (num),
    .num_valid (num_valid),
    .draw_cnt  (draw_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 2'b00;
    seed_load = 1'b0;
    seed_in = 4'b0000;
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  logic [3:0] seq [16];
  logic [1:0] alt [4];

  initial begin
    seq = '{4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001};
    alt = '{2'b01, 2'b10, 2'b01, 2'b10};
    n_checks = 0;
    n_errors = 0;

    // 1. Reset and first draw
    rst = 1'b0;
    req = 2'b00;
    seed_load = 1'b0;
    seed_in = 4'b0000;
    repeat (10) step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_num", 32'(num), 32'h0);
    check("rst_valid", 32'(num_valid), 32'h0);
    check("rst_cnt", 32'(draw_cnt), 32'h0);
    rst = 1'b1;
    repeat (5) step();
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_valid", 32'(num_valid), 32'h0);
    check("idle_cnt", 32'(draw_cnt), 32'h0);
    req = 2'b01;
    step();
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_num", 32'(num), 32'h9);
    check("first_valid", 32'(num_valid), 32'h1);
    check("first_cnt", 32'(draw_cnt), 32'h1);
    req = 2'b00;
    step();
    check("after_gnt", 32'(gnt), 32'h0);
    check("after_valid", 32'(num_valid), 32'h0);
    check("after_num_hold", 32'(num), 32'h9);

    // 2. Single requester
    do_reset();
    req = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      check("single_gnt", 32'(gnt), 32'h2);
      check("single_num", 32'(num), 32'(seq[i]));
    end
    check("single_cnt", 32'(draw_cnt), 32'h4);

    // 3. Contention
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      check("cont_gnt", 32'(gnt), 32'(alt[i]));
      check("cont_num", 32'(num), 32'(seq[i]));
    end

    // 4. Seed load beats request
    req = 2'b01;
    seed_load = 1'b1;
    seed_in = 4'b0101;
    step();
    check("seed_gnt", 32'(gnt), 32'h0);
    check("seed_valid", 32'(num_valid), 32'h0);
    check("seed_num_hold", 32'(num), 32'hd);
    check("seed_cnt_hold", 32'(draw_cnt), 32'h4);
    seed_load = 1'b0;
    step();
    check("seed_draw0_gnt", 32'(gnt), 32'h1);
    check("seed_draw0_num", 32'(num), 32'h5);
    step();
    check("seed_draw1_num", 32'(num), 32'hb);
    check("seed_cnt", 32'(draw_cnt), 32'h6);

    // 5. Zero seed substitutes SEED
    req = 2'b00;
    seed_load = 1'b1;
    seed_in = 4'b0000;
    step();
    seed_load = 1'b0;
    req = 2'b01;
    step();
    check("zero_seed_num", 32'(num), 32'h9);
    check("zero_seed_valid", 32'(num_valid), 32'h1);
    req = 2'b00;
    step();

    // 6. Full period, then asynchronous reset mid-grant
    do_reset();
    req = 2'b01;
    for (int i = 0; i < 16; i++) begin
      step();
      check("period_num", 32'(num), 32'(seq[i]));
    end
    check("period_cnt", 32'(draw_cnt), 32'd16);
    step();
    check("pre_rst_valid", 32'(num_valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_valid", 32'(num_valid), 32'h0);
    check("async_cnt", 32'(draw_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h1);
    check("post_rst_num", 32'(num), 32'h9);
    req = 2'b00;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
